// File: rtl/day_9_rr_arbiter_bin_if.sv
// rtl/day_9_rr_arbiter_bin_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface day_9_rr_arbiter_bin_if #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
);

  logic [NUM_REQ-1:0] req_i;
  logic               gnt_ack_i;
  logic               gnt_valid_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic [IDX_W-1:0]   last_idx_o;

  // requester/consumer side
  modport master (
    output req_i,
    output gnt_ack_i,
    input  gnt_valid_o,
    input  gnt_idx_o,
    input  last_idx_o
  );

  // arbiter side
  modport slave (
    input  req_i,
    input  gnt_ack_i,
    output gnt_valid_o,
    output gnt_idx_o,
    output last_idx_o
  );

endinterface

// File: rtl/day_9_rr_arbiter_bin.sv
// rtl/day_9_rr_arbiter_bin.sv - round-robin arbiter with registered binary grant index and valid/ack handshake
module day_9_rr_arbiter_bin #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  day_9_rr_arbiter_bin_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  generate
    if (NUM_REQ < 2 || NUM_REQ > (2 ** IDX_W)) begin : g_bad_param
      $error("day_9_rr_arbiter_bin: NUM_REQ must lie in 2..2**IDX_W");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic               gnt_valid_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [IDX_W-1:0]   last_idx_q;

  logic [NUM_REQ-1:0] req_others;
  logic [IDX_W-1:0]   pick_idle;
  logic [IDX_W-1:0]   pick_next;

  // First requesting index strictly after ptr, wrapping at NUM_REQ-1 -> 0.
  // The wrap is a conditional subtract so indices >= NUM_REQ never appear,
  // even when NUM_REQ is not a power of two. ptr itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [IDX_W-1:0]   ptr,
    input logic [NUM_REQ-1:0] req
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [IDX_W:0]   cand;
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && |(req & (NUM_REQ'(1) << cand[IDX_W-1:0]))) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Candidate winners: from the priority pointer when idle, and from the
  // current grant (which becomes the new pointer) with its own bit masked
  // so a back-to-back grant never repeats the requester just served.
  always_comb begin
    req_others = bus.req_i & ~(NUM_REQ'(1) << gnt_idx_q);
    pick_idle  = rr_pick(last_idx_q, bus.req_i);
    pick_next  = rr_pick(gnt_idx_q, req_others);
  end

  // Grant FSM: present a sticky grant until acked, then chain or go idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      last_idx_q  <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_i) begin
            gnt_idx_q   <= pick_idle;
            gnt_valid_q <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (bus.gnt_ack_i) begin
            last_idx_q <= gnt_idx_q;
            if (|req_others) begin
              gnt_idx_q <= pick_next;
            end else begin
              gnt_valid_q <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_valid_o = gnt_valid_q;
  assign bus.gnt_idx_o   = gnt_idx_q;
  assign bus.last_idx_o  = last_idx_q;

endmodule

// File: tb/tb_day_9_rr_arbiter_bin.sv
// tb/tb_day_9_rr_arbiter_bin.sv - scoreboard bench for the round-robin arbiter (16- and 5-requester builds)
module tb_day_9_rr_arbiter_bin;

  logic clk;
  logic reset;

  day_9_rr_arbiter_bin_if #(.NUM_REQ(16), .IDX_W(4)) bus16 ();
  day_9_rr_arbiter_bin_if #(.NUM_REQ(5),  .IDX_W(3)) bus5  ();

  day_9_rr_arbiter_bin #(.NUM_REQ(16), .IDX_W(4)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  day_9_rr_arbiter_bin #(.NUM_REQ(5), .IDX_W(3)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int idx;
    int last;
  } exp_t;

  exp_t q16[$];
  exp_t q5[$];

  int total = 0;
  int bad   = 0;

  // reference model state: [0] = 16 requesters, [1] = 5 requesters
  int nreq   [2] = '{16, 5};
  bit m_valid[2];
  int m_idx  [2];
  int m_last [2];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input int ptr, input int n, input logic [15:0] r);
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0;
      m_idx[u]   = 0;
      m_last[u]  = nreq[u] - 1;
    end
  endtask

  task automatic model_step(input int u, input logic [15:0] r, input bit ack);
    logic [15:0] rest;
    if (!m_valid[u]) begin
      if (r != 0) begin
        m_idx[u]   = winner(m_last[u], nreq[u], r);
        m_valid[u] = 1'b1;
      end
    end else if (ack) begin
      m_last[u] = m_idx[u];
      rest = r;
      rest[m_idx[u]] = 1'b0;
      if (rest != 0) m_idx[u] = winner(m_last[u], nreq[u], rest);
      else           m_valid[u] = 1'b0;
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, predict
  // the outputs after that edge and queue them, then advance to the next falling edge.
  task automatic cycle(input logic [15:0] r16, input logic [4:0] r5, input bit ack);
    exp_t e;
    bus16.req_i     = r16;
    bus16.gnt_ack_i = ack;
    bus5.req_i      = r5;
    bus5.gnt_ack_i  = ack;
    model_step(0, r16, ack);
    model_step(1, {11'd0, r5}, ack);
    e.v = m_valid[0]; e.idx = m_idx[0]; e.last = m_last[0];
    q16.push_back(e);
    e.v = m_valid[1]; e.idx = m_idx[1]; e.last = m_last[1];
    q5.push_back(e);
    @(negedge clk);
  endtask

  // Asserted away from any clock edge: outputs must drop at once.
  task automatic do_reset();
    reset           = 1'b1;
    bus16.req_i     = '0;
    bus16.gnt_ack_i = 1'b0;
    bus5.req_i      = '0;
    bus5.gnt_ack_i  = 1'b0;
    #1;
    check("rst_valid16", bus16.gnt_valid_o, 0);
    check("rst_idx16",   bus16.gnt_idx_o,   0);
    check("rst_last16",  bus16.last_idx_o,  15);
    check("rst_valid5",  bus5.gnt_valid_o,  0);
    check("rst_idx5",    bus5.gnt_idx_o,    0);
    check("rst_last5",   bus5.last_idx_o,   4);
    model_reset();
    q16.delete();
    q5.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: every rising edge outside reset yields one queued prediction per DUT
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check("valid16", bus16.gnt_valid_o, e.v);
        check("idx16",   bus16.gnt_idx_o,   e.idx);
        check("last16",  bus16.last_idx_o,  e.last);
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        check("valid5", bus5.gnt_valid_o, e.v);
        check("idx5",   bus5.gnt_idx_o,   e.idx);
        check("last5",  bus5.last_idx_o,  e.last);
        if (bus5.gnt_valid_o) check("idx5_range", (bus5.gnt_idx_o < 3'd5) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    int wait_cnt;
    reset           = 1'b1;
    bus16.req_i     = '0;
    bus16.gnt_ack_i = 1'b0;
    bus5.req_i      = '0;
    bus5.gnt_ack_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // idle with no requests
    repeat (5) cycle(16'h0000, 5'b00000, 1'b0);

    // two requesters, ack tied high: alternating grants with no bubble
    do_reset();
    repeat (8) cycle(16'h8001, 5'b10001, 1'b1);

    // short request, grant held sticky until the ack pulse
    do_reset();
    cycle(16'h0010, 5'b00100, 1'b0);
    repeat (4) cycle(16'h0000, 5'b00000, 1'b0);
    cycle(16'h0000, 5'b00000, 1'b1);
    repeat (2) cycle(16'h0000, 5'b00000, 1'b0);

    // move the pointer to 14 (and 3 on the small build), then wrap
    do_reset();
    cycle(16'h4000, 5'b01000, 1'b0);
    cycle(16'h0000, 5'b00000, 1'b1);
    repeat (5) cycle(16'h4003, 5'b11001, 1'b1);

    // single requester held: grant, bubble, grant
    do_reset();
    repeat (6) cycle(16'h0200, 5'b00010, 1'b1);

    // reset dropped in the middle of an outstanding grant
    do_reset();
    cycle(16'h0080, 5'b00100, 1'b0);
    #2;
    do_reset();
    cycle(16'h0080, 5'b00100, 1'b0);
    cycle(16'h0080, 5'b00100, 1'b1);
    cycle(16'h0000, 5'b00000, 1'b0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r16;
      logic [4:0]  r5;
      bit          ack;
      r16 = 16'($urandom) & 16'($urandom);
      r5  = 5'($urandom) & 5'($urandom);
      if ($urandom_range(0, 7) == 0) r16 = '0;
      if ($urandom_range(0, 7) == 0) r5  = '0;
      ack = ($urandom_range(0, 3) != 0);
      cycle(r16, r5, ack);
    end

    // drain: every prediction must be consumed within a few edges
    wait_cnt = 0;
    while ((q16.size() > 0 || q5.size() > 0) && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain", q16.size() + q5.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
